// File: rtl/systolic_pe_v3.sv
// Weight-stationary systolic PE: double-buffered weight, registered act/psum forwarding, MAC counter.
// Latency: act, psum and weight chain each 1 cycle; a swap takes effect on the MAC after the swap edge.
// Backpressure: none; every valid beat is accepted. Optional saturation via SYSTOLIC_PE_SAT_EN.
module systolic_pe_v3 #(
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32,
  parameter int BW_CNT  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic signed [BW_ACT-1:0]  act_in,
  input  logic                      act_valid_in,
  output logic signed [BW_ACT-1:0]  act_out,
  output logic                      act_valid_out,
  input  logic signed [BW_ACCU-1:0] psum_in,
  output logic signed [BW_ACCU-1:0] psum_out,
  input  logic signed [BW_WET-1:0]  wet_in,
  input  logic                      wet_shift_en,
  output logic signed [BW_WET-1:0]  wet_out,
  input  logic                      wet_swap,
  input  logic                      clear_weight,
  input  logic                      bypass_en,
  output logic [BW_CNT-1:0]         mac_count
);

  localparam int BW_PROD = BW_ACT + BW_WET;
  localparam logic [BW_CNT-1:0] CNT_MAX = '1;

  // The accumulator must hold a full-precision product.
  generate
    if (BW_ACCU < BW_PROD) begin : g_bad_accu_width
      $error("systolic_pe_v3: BW_ACCU must be >= BW_ACT + BW_WET");
    end
  endgenerate

  logic signed [BW_WET-1:0]  shadow_w;
  logic signed [BW_WET-1:0]  active_w;
  logic signed [BW_PROD-1:0] prod;
  logic signed [BW_ACCU-1:0] prod_ext;
  logic signed [BW_ACCU-1:0] mac_res;

  assign wet_out = shadow_w;

`ifdef SYSTOLIC_PE_SAT_EN
  logic signed [BW_ACCU:0] sum_ext;

  // Multiply-add with one guard bit; clamp when the guard and sign bits disagree.
  always_comb begin
    prod     = BW_PROD'(act_in) * BW_PROD'(active_w);
    prod_ext = BW_ACCU'(prod);
    sum_ext  = (BW_ACCU+1)'(psum_in) + (BW_ACCU+1)'(prod_ext);
    mac_res  = sum_ext[BW_ACCU-1:0];
    if (sum_ext[BW_ACCU] != sum_ext[BW_ACCU-1]) begin
      mac_res = sum_ext[BW_ACCU] ? {1'b1, {(BW_ACCU-1){1'b0}}}
                                 : {1'b0, {(BW_ACCU-1){1'b1}}};
    end
  end
`else
  // Multiply-add wrapping modulo 2^BW_ACCU.
  always_comb begin
    prod     = BW_PROD'(act_in) * BW_PROD'(active_w);
    prod_ext = BW_ACCU'(prod);
    mac_res  = psum_in + prod_ext;
  end
`endif

  // Weight double buffer: clear wins; swap captures the pre-edge shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_w <= '0;
      active_w <= '0;
    end else if (clear_weight) begin
      shadow_w <= '0;
      active_w <= '0;
    end else begin
      if (wet_shift_en) shadow_w <= wet_in;
      if (wet_swap)     active_w <= shadow_w;
    end
  end

  // Activation/partial-sum forwarding; outputs hold on idle beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_out       <= '0;
      act_valid_out <= 1'b0;
      psum_out      <= '0;
    end else begin
      act_valid_out <= act_valid_in;
      if (act_valid_in) begin
        act_out  <= act_in;
        psum_out <= bypass_en ? psum_in : mac_res;
      end
    end
  end

  // MAC counter for the current active weight, saturating; swap/clear restart it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_count <= '0;
    end else if (clear_weight || wet_swap) begin
      mac_count <= '0;
    end else if (act_valid_in && !bypass_en && (mac_count != CNT_MAX)) begin
      mac_count <= mac_count + 1'b1;
    end
  end

endmodule

// File: doc/systolic_pe_v3.md
# systolic_pe_v3

Weight-stationary processing element for the next-generation systolic array, parametrised in activation, weight and accumulator width. It adds three things to the single-register PE generation:
- a double-buffered weight: a shadow register loaded through a vertical shift chain, and an active register used by the MAC;
- registered activation and partial-sum forwarding, with valid tagging;
- a per-weight MAC counter.

Tiles of this block form the array core; the array controller drives shift, swap, clear and bypass globally.

## Interface
- BW_ACT, 8, signed activation width
- BW_WET, 8, signed weight width
- BW_ACCU, 32, signed partial-sum width; must be ≥ BW_ACT+BW_WET (elaboration error otherwise)
- BW_CNT, 16, MAC counter width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- act_in  in  BW_ACT  signed activation from left neighbour
- act_valid_in  in  1  act_in/psum_in qualifier
- act_out  out  BW_ACT  registered activation to right neighbour
- act_valid_out  out  1  registered act_valid_in
- psum_in  in  BW_ACCU  signed partial sum from PE above
- psum_out  out  BW_ACCU  registered partial sum to PE below
- wet_in  in  BW_WET  weight shift-chain input from PE above
- wet_shift_en  in  1  load shadow weight from wet_in
- wet_out  out  BW_WET  shadow weight to PE below (shift chain)
- wet_swap  in  1  copy shadow weight into active weight
- clear_weight  in  1  synchronous clear of both weight registers and counter
- bypass_en  in  1  1: psum_out forwards psum_in unchanged
- mac_count  out  BW_CNT  valid MACs performed with current active weight

## Operation
- Weight shadow:
  - shadow <= wet_in on wet_shift_en.
  - wet_out = shadow, driven directly from the register.
  - A column of N PEs loads N weights in N shift cycles.
- Weight active:
  - active <= shadow (pre-edge value) on wet_swap.
  - Shift and swap in the same cycle: active gets the old shadow; shadow gets wet_in.
- clear_weight has priority over shift and swap. It zeroes shadow, active and mac_count.
- Datapath, on each edge with act_valid_in=1:
  - act_out <= act_in; act_valid_out <= 1.
  - psum_out <= bypass_en ? psum_in : psum_in + act_in*active.
  - MAC uses the pre-edge active weight, even when wet_swap is asserted in the same cycle.
- On edges with act_valid_in=0: act_valid_out <= 0; act_out and psum_out hold.
- Arithmetic:
  - Product is a full-precision signed BW_ACT+BW_WET result, sign-extended to BW_ACCU.
  - The sum wraps modulo 2^BW_ACCU unless the saturation feature is compiled in (see Configuration).
- Counter (mac_count):
  - +1 per valid non-bypass MAC.
  - Saturates at 2^BW_CNT−1.
  - Reset to 0 on wet_swap or clear_weight; swap wins over a same-cycle increment.
- Weight state, tracked by the controller and implied by the registers:
  - EMPTY → (shift) LOADING → (swap) ACTIVE.
  - ACTIVE continues shifting the next weight while computing. No stall.

## Timing
- Reset values: act_out=0, act_valid_out=0, psum_out=0, wet_out=0, mac_count=0, internal active weight=0.
- Latency:
  - act_in→act_out: 1 cycle.
  - psum_in→psum_out: 1 cycle.
  - wet_in→wet_out: 1 cycle.
  - Swap effective for MACs from the cycle after the swap edge.
- No back-pressure; the PE accepts every valid beat.
- reset_n assertion mid-stream clears all state immediately. First valid output after deassertion requires a new act_valid_in.
- Single combinational multiply-add between registers. No internal pipeline stage.

## Configuration
- SYSTOLIC_PE_SAT_EN defined: psum_out saturates to signed max (2^(BW_ACCU−1)−1) or min (−2^(BW_ACCU−1)) on overflow of psum_in + product.
- SYSTOLIC_PE_SAT_EN undefined: two's-complement wrap.

## Test plan
- Reset: assert reset_n=0 mid-traffic → all outputs 0 within the same cycle; hold for 3 cycles with random inputs → outputs stay 0.
- Shift/swap:
  - Shift 5 then swap, with act_in=3, psum_in=10, valid → psum_out=25 one cycle later, mac_count=1.
  - Same cycle as swap, with active=2 → psum_out uses 2.
- Double-buffer: while computing with weight 5, shift in −4 over the chain without swap → outputs keep using 5; after swap, act_in=−128, psum_in=0 → psum_out=512.
- Bypass/valid: bypass_en=1, psum_in=0x1234 → psum_out=0x1234, mac_count unchanged; act_valid_in=0 → psum_out, act_out hold, act_valid_out=0.
- Overflow (BW_ACCU=16): psum_in=32767, act=1, w=1 → psum_out=−32768 without SYSTOLIC_PE_SAT_EN, 32767 with it.
- Clear/counter (BW_CNT=2): 5 valid MACs → mac_count=3 (saturated); clear_weight with shift and swap asserted → shadow=0, active=0, mac_count=0.
